// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: icache request/response and fetch-queue packets.
// Default fetch-queue depth lives here so the top and the bench agree.
package fetch_unit_pkg;

  localparam int FQ_DEPTH_DEF = 8;

  typedef logic [31:0] ADDR;

  typedef struct packed {
    logic valid;
    ADDR  addr;
  } I_ADDR_PACKET;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } CACHE_DATA;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    ADDR         pc;
  } FETCH_PACKET;

  typedef struct packed {
    logic [31:0] inst;
    ADDR         pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// fetch_queue: 2-in/2-out circular buffer with flush and a two-entry head window.
// Pops beyond the current occupancy are clamped.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               push_count,
  input  fq_entry_t [1:0]          push_data,
  input  logic [1:0]               pop_count,
  output logic [$clog2(DEPTH):0]   count,
  output FETCH_PACKET [1:0]        head_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pop_ext, pop_eff;
  fq_entry_t     mem_q [DEPTH];
  fq_entry_t     mem_d [DEPTH];

  always_comb begin
    pop_ext = CW'(pop_count);
    pop_eff = (pop_ext > count_q) ? count_q : pop_ext;
    head_d  = head_q + AW'(pop_eff);
    tail_d  = tail_q + AW'(push_count);
    count_d = count_q - pop_eff + CW'(push_count);
    mem_d   = mem_q;
    if (push_count != 2'd0) mem_d[tail_q] = push_data[0];
    if (push_count == 2'd2) mem_d[tail_q + AW'(1)] = push_data[1];
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      head_out[i].valid = (count_q > CW'(i));
      head_out[i].inst  = mem_q[head_q + AW'(i)].inst;
      head_out[i].pc    = mem_q[head_q + AW'(i)].pc;
    end
  end

  assign count = count_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && !flush)
      assert (CW'(pop_count) <= count_q)
        else $error("fetch_queue: pop_count %0d over count %0d",
                    pop_count, count_q);
  end
`endif

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: 2-wide fetch stage; owns the PC, gates icache requests, fills fetch_queue.
// Optional FETCH_PERF_COUNTERS_EN adds stall_cycles / fetched_insts counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          FQ_DEPTH = FQ_DEPTH_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  output I_ADDR_PACKET [1:0]          read_addrs,
  input  CACHE_DATA [1:0]             cache_outs,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  input  logic [1:0]                  pop_count,
  output FETCH_PACKET [1:0]           fq_out,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 fetched_insts
`endif
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count;
  logic          room_ok;
  logic          fetch_ok;
  logic [1:0]    push_count;
  fq_entry_t [1:0] push_data;

  // Uses pre-pop occupancy, so two free slots are guaranteed.
  assign room_ok  = (count <= CW'(FQ_DEPTH - 2));
  assign fetch_ok = ~redirect_valid & room_ok;

  always_comb begin
    read_addrs[0].valid = fetch_ok;
    read_addrs[0].addr  = pc_q;
    read_addrs[1].valid = fetch_ok;
    read_addrs[1].addr  = pc_q + 32'd4;
    push_count = 2'd0;
    if (fetch_ok && cache_outs[0].valid)
      push_count = cache_outs[1].valid ? 2'd2 : 2'd1;
    for (int i = 0; i < 2; i++) begin
      push_data[i].inst = cache_outs[i].data;
      push_data[i].pc   = read_addrs[i].addr;
    end
    pc_d = redirect_valid ? redirect_pc
                          : pc_q + {28'd0, push_count, 2'b00};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk        (clock),
    .rst        (reset),
    .flush      (redirect_valid),
    .push_count (push_count),
    .push_data  (push_data),
    .pop_count  (pop_count),
    .count      (count),
    .head_out   (fq_out)
  );

  assign fq_count = count;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] fetched_q, fetched_d;
  logic        stall;

  always_comb begin
    stall     = (fetch_ok & ~cache_outs[0].valid)
              | (~redirect_valid & ~room_ok);
    stall_d   = stall_q;
    fetched_d = fetched_q;
    if (stall && stall_q != '1) stall_d = stall_q + 32'd1;
    if ({1'b0, fetched_q} + {31'd0, push_count} > 33'hFFFF_FFFF)
      fetched_d = '1;
    else
      fetched_d = fetched_q + {30'd0, push_count};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q   <= '0;
      fetched_q <= '0;
    end else begin
      stall_q   <= stall_d;
      fetched_q <= fetched_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign fetched_insts = fetched_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural same-cycle icache.
// Hit pattern per slot is driven by the stimulus; data is a fixed function of address.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  I_ADDR_PACKET [1:0] read_addrs;
  CACHE_DATA [1:0]   cache_outs;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [1:0]        pop_count;
  FETCH_PACKET [1:0] fq_out;
  logic [3:0]        fq_count;
  logic [1:0]        hit;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       fetched_insts;
`endif

  int nvec = 0;
  int nerr = 0;

  fetch_unit #(
    .RESET_PC (32'h0),
    .FQ_DEPTH (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .read_addrs     (read_addrs),
    .cache_outs     (cache_outs),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pop_count      (pop_count),
    .fq_out         (fq_out),
    .fq_count       (fq_count)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .stall_cycles   (stall_cycles),
    .fetched_insts  (fetched_insts)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cache_outs[i].valid = read_addrs[i].valid & hit[i];
      cache_outs[i].data  = inst_of(read_addrs[i].addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    pop_count = '0;
    hit = 2'b00;
    #1;
    chk("rst_count", 32'(fq_count), 0);
    chk("rst_v0", 32'(fq_out[0].valid), 0);
    chk("rst_pc", read_addrs[0].addr, 32'h0);
    cyc();
    cyc();
    reset = 1'b0;

    // Fill to full with double hits.
    hit = 2'b11;
    #1;
    chk("req0_v", 32'(read_addrs[0].valid), 1);
    chk("req1_a", read_addrs[1].addr, 32'h4);
    for (int i = 0; i < 4; i++) begin
      chk("fill_a0", read_addrs[0].addr, 32'(8 * i));
      cyc();
      chk("fill_cnt", 32'(fq_count), 32'(2 * (i + 1)));
    end
    chk("full_req_v0", 32'(read_addrs[0].valid), 0);
    chk("full_req_v1", 32'(read_addrs[1].valid), 0);
    chk("full_pc0", fq_out[0].pc, 32'h0);
    chk("full_pc1", fq_out[1].pc, 32'h4);
    chk("full_inst0", fq_out[0].inst, inst_of(32'h0));
    chk("full_inst1", fq_out[1].inst, inst_of(32'h4));
    cyc();
    chk("full_hold", 32'(fq_count), 8);

    // One slot free: still no requests.
    pop_count = 2'd1;
    cyc();
    pop_count = 2'd0;
    #1;
    chk("m1_cnt", 32'(fq_count), 7);
    chk("m1_req_v", 32'(read_addrs[0].valid), 0);
    chk("m1_head", fq_out[0].pc, 32'h4);
    cyc();
    chk("m1_hold", 32'(fq_count), 7);

    // Redirect while nearly full.
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("rd1_req_v", 32'(read_addrs[0].valid), 0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("rd1_cnt", 32'(fq_count), 0);
    chk("rd1_v0", 32'(fq_out[0].valid), 0);
    chk("rd1_pc", read_addrs[0].addr, 32'h40);

    // [0] hit, [1] miss.
    hit = 2'b01;
    cyc();
    chk("h01_cnt", 32'(fq_count), 1);
    chk("h01_pc", fq_out[0].pc, 32'h40);
    chk("h01_v1", 32'(fq_out[1].valid), 0);
    chk("h01_a0", read_addrs[0].addr, 32'h44);
    chk("h01_a1", read_addrs[1].addr, 32'h48);

    // Hit on [1] alone is discarded.
    hit = 2'b10;
    cyc();
    chk("h10_cnt", 32'(fq_count), 1);
    chk("h10_a0", read_addrs[0].addr, 32'h44);

    // Redirect, then [0] misses for three cycles.
    hit = 2'b00;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    cyc();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("miss_a0", read_addrs[0].addr, 32'h80);
      chk("miss_v0", 32'(read_addrs[0].valid), 1);
      cyc();
      chk("miss_cnt", 32'(fq_count), 0);
    end
    hit = 2'b11;
    cyc();
    chk("mh_cnt", 32'(fq_count), 2);
    chk("mh_pc0", fq_out[0].pc, 32'h80);
    chk("mh_pc1", fq_out[1].pc, 32'h84);
    chk("mh_a0", read_addrs[0].addr, 32'h88);

    // Steady state across pointer wrap.
    pop_count = 2'd2;
    exp_pc = 32'h80;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("ss_cnt", 32'(fq_count), 2);
      chk("ss_pc0", fq_out[0].pc, exp_pc);
      chk("ss_pc1", fq_out[1].pc, exp_pc + 32'd4);
      chk("ss_inst1", fq_out[1].inst, inst_of(exp_pc + 32'd4));
      cyc();
      exp_pc = exp_pc + 32'd8;
    end
    pop_count = 2'd0;

    // Build count=5, then redirect with simultaneous pop.
    cyc();
    chk("b_cnt4", 32'(fq_count), 4);
    hit = 2'b01;
    cyc();
    chk("b_cnt5", 32'(fq_count), 5);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    pop_count = 2'd2;
    #1;
    chk("rd2_v0", 32'(read_addrs[0].valid), 0);
    chk("rd2_v1", 32'(read_addrs[1].valid), 0);
    cyc();
    redirect_valid = 1'b0;
    pop_count = 2'd0;
    hit = 2'b00;
    #1;
    chk("rd2_cnt", 32'(fq_count), 0);
    chk("rd2_a0", read_addrs[0].addr, 32'h200);
    chk("rd2_fqv", 32'(fq_out[0].valid), 0);

    // PC wraps at 2^32.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect_valid = 1'b0;
    hit = 2'b11;
    #1;
    chk("wr_a1", read_addrs[1].addr, 32'hFFFF_FFFC);
    cyc();
    chk("wr_cnt", 32'(fq_count), 2);
    chk("wr_pc1", fq_out[1].pc, 32'hFFFF_FFFC);
    chk("wr_a0", read_addrs[0].addr, 32'h0);
    cyc();
    cyc();
    hit = 2'b00;
    chk("pre_rst_cnt", 32'(fq_count), 6);

    // Asynchronous reset mid-cycle.
    #2;
    reset = 1'b1;
    #1;
    chk("arst_cnt", 32'(fq_count), 0);
    chk("arst_v0", 32'(fq_out[0].valid), 0);
    chk("arst_v1", 32'(fq_out[1].valid), 0);
    chk("arst_pc", read_addrs[0].addr, 32'h0);
    cyc();
    reset = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
